irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Programmable interrupt controller between the interrupt sources (TC1 IRQ, TC2 IRQ, external `interrupt`, three spare lines) and the CPU's 6-bit HWInt input. It latches and masks requests and prioritises them, lowest index highest. It tracks in-service interrupts so that only higher-priority requests can preempt, and presents one registered request line plus a vector. The Bridge maps it as a 4-word peripheral and drives `addr`/`we`/`din`.

## Interface
- `N_SRC`, 6: number of sources; fixed width of `src`/`hwint`; legal 1..8.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `src` input N_SRC: raw requests, synchronous to `clk`; bit 0 highest priority.
- `addr` input 2: word offset within the controller window, already decoded by the Bridge.
- `we` input 1: write strobe for the addressed register, one cycle per write.
- `din` input 32: write data.
- `dout` output 32: read data of addressed register; combinational from `addr`.
- `irq` output 1: registered request to CPU.
- `hwint` output N_SRC: registered `pending & mask`, for the CPU's Cause.IP field.

## Operation
- State: `src_q`, `pending`, `mask`, `mode` (1 = edge, 0 = level), `insvc` (each N_SRC bits), `irq`, `hwint`.
- Edge source: `src & ~src_q` sets `pending` bit.
- Level source: `pending` bit = `src_q` bit every cycle; writes never clear it.
- `top` = lowest index set in `pending & mask`; `topsvc` = lowest index set in `insvc`.
- `req` = (`pending & mask` != 0) and (`insvc` == 0 or `top` < `topsvc`).
- Register map:
  - Offset 0 PEND: read {0, pending}. Write-1-to-clear edge-mode bits only.
  - Offset 1 MASK: read/write bits [N_SRC-1:0]. Upper bits read 0.
  - Offset 2 MODE: read/write bits [N_SRC-1:0]. Upper bits read 0.
  - Offset 3 CTRL:
    - Read {req, 15'b0, 2'b0, insvc in [13:8] (zero-extended), 5'b0, top in [2:0]}. `top` reads 0 when nothing is pending.
    - Write with din[31]=1 is CLAIM. If `req`, set `insvc[top]` and clear `pending[top]` when that source is edge mode. If not `req`, there is no effect.
    - Write with din[31]=0 is EOI. Clear `insvc[topsvc]`. No effect when `insvc` is 0.
- Simultaneous events on the same bit in the same cycle:
  - New edge and W1C: set wins.
  - New edge and CLAIM: the bit stays pending and `insvc` is still set.
  - Mode change: the new mode applies from the next cycle.
- Masking a bit does not clear `pending` or `insvc`.
- Unmasking a bit that is still pending raises `irq` per the normal latency.

## Timing
- Reset values: `src_q`, `pending`, `mask`, `mode`, `insvc` are 0. `irq` is 0, `hwint` is 0. `dout` follows `addr` and is 0 at every offset.
- Edge source, `src` rises before edge E:
  - `src_q` and `pending` update at E.
  - `irq` and `hwint` update at E+1.
  - 2-cycle latency with the source unmasked.
- Level source: same 2-cycle assert latency. Deassertion of `src` clears `pending` at E and drops `irq` at E+1.
- Register writes take effect at the clock edge where `we`=1. `irq` reflects them one edge later.
- A read in the same cycle as a write returns the pre-write value.
- A pulse of one cycle on an edge source is captured. A source held high produces exactly one pending event.
- `reset` asserted mid-operation clears everything asynchronously. After release, the first edge samples `src` into `src_q` with no edge detected for sources already high.

## Test plan
- Reset, MASK=6'h3f, MODE=0. Raise `src[1]` (TC2 level) -> `irq`=1 and `hwint`=6'h02 two cycles later. CTRL reads 0x8000_0001. Drop `src[1]` -> `irq`=0 two cycles later.
- Edge mode, one-cycle pulse on `src[2]` -> PEND=0x04 held. Write PEND=0x04 -> PEND=0. A W1C coincident with a new pulse -> PEND stays 0x04.
- Priority and nesting:
  - Pending 0x0C, CLAIM -> `insvc`=0x04, `irq` stays 1 only if bit 3 < bit 2, so `irq`=0.
  - Raise `src[0]` -> `irq`=1 and `top`=0. CLAIM -> `insvc`=0x05.
  - EOI -> `insvc`=0x04. EOI -> `insvc`=0 and `irq`=1 for pending bit 3.
- MASK=0 with all sources active -> `irq`=0 and `hwint`=0, while PEND reflects the sources. Write MASK=0x20 -> `hwint`=0x20 and `irq`=1 two edges later.
- Async reset asserted mid-cycle while `irq`=1 and `insvc`=0x01 -> `irq`, `hwint`, all registers are 0 before the next clock edge.
- CLAIM with `req`=0 and EOI with `insvc`=0 -> no state change.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: latches, masks and nests up to N_SRC
// request lines and presents one registered request plus vector to the CPU.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             irq,
    output logic [N_SRC-1:0] hwint
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] insvc_q, insvc_d;
    logic             irq_q;
    logic [N_SRC-1:0] hwint_q;

    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] edge_new;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] top_oh;
    logic [N_SRC-1:0] svc_oh;
    logic [2:0]       top;
    logic [2:0]       topsvc;
    logic             req;
    logic             wr_pend, wr_mask, wr_mode, wr_ctrl;
    logic             claim, eoi;
    logic [31:0]      ctrl_rd;
    logic             unused_din;

    function automatic logic [2:0] lowest(input logic [N_SRC-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign active   = pending_q & mask_q;
    assign edge_new = src & ~src_q;
    assign top      = lowest(active);
    assign topsvc   = lowest(insvc_q);
    assign top_oh   = N_SRC'(1) << top;
    assign svc_oh   = N_SRC'(1) << topsvc;

    // Only a strictly higher-priority request may preempt in-service work.
    assign req = (|active) && ((insvc_q == '0) || (top < topsvc));

    assign wr_pend = we && (addr == 2'd0);
    assign wr_mask = we && (addr == 2'd1);
    assign wr_mode = we && (addr == 2'd2);
    assign wr_ctrl = we && (addr == 2'd3);
    assign claim   = wr_ctrl && din[31] && req;
    assign eoi     = wr_ctrl && !din[31] && (insvc_q != '0);

    assign unused_din = ^din[30:N_SRC];

    always_comb begin
        mask_d  = mask_q;
        mode_d  = mode_q;
        insvc_d = insvc_q;
        clr     = '0;
        if (wr_pend) clr = din[N_SRC-1:0];
        if (wr_mask) mask_d = din[N_SRC-1:0];
        if (wr_mode) mode_d = din[N_SRC-1:0];
        if (claim) begin
            insvc_d = insvc_q | top_oh;
            clr     = clr | top_oh;
        end
        if (eoi) insvc_d = insvc_q & ~svc_oh;
        // A fresh edge overrides any clear in the same cycle.
        pending_d = (mode_q & ((pending_q & ~clr) | edge_new))
                  | (~mode_q & src);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            insvc_q   <= '0;
            irq_q     <= 1'b0;
            hwint_q   <= '0;
        end else begin
            src_q     <= src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            insvc_q   <= insvc_d;
            irq_q     <= req;
            hwint_q   <= active;
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[31]          = req;
        ctrl_rd[8 +: N_SRC]  = insvc_q;
        ctrl_rd[2:0]         = top;
    end

    always_comb begin
        dout = '0;
        unique case (addr)
            2'd0: dout = 32'(pending_q);
            2'd1: dout = 32'(mask_q);
            2'd2: dout = 32'(mode_q);
            2'd3: dout = ctrl_rd;
        endcase
    end

    assign irq   = irq_q;
    assign hwint = hwint_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand-built reset sequence,
// then random traffic against a per-source reference model.
module tb_irq_ctrl;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  src = '0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq;
    logic [5:0]  hwint;

    always #10 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we),
        .din(din), .dout(dout), .irq(irq), .hwint(hwint)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  src;
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] dout;
        logic        irq;
        logic [5:0]  hw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] s, input logic [1:0] a,
                                input logic w, input logic [31:0] d,
                                input logic [31:0] o, input logic i,
                                input logic [5:0] h);
        vec_t v;
        v.src = s; v.addr = a; v.we = w; v.din = d;
        v.dout = o; v.irq = i; v.hw = h;
        return v;
    endfunction

    // Reference model: per-source bits, priority by lowest index.
    bit [5:0] m_prev, m_pend, m_mask, m_mode, m_svc, m_hw;
    bit       m_irq;

    function automatic int first_set(input bit [5:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit m_req();
        int t, s;
        t = first_set(m_pend & m_mask);
        s = first_set(m_svc);
        return (t >= 0) && (s < 0 || t < s);
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        int t;
        logic [31:0] r;
        t = first_set(m_pend & m_mask);
        case (a)
            2'd0: r = 32'(m_pend);
            2'd1: r = 32'(m_mask);
            2'd2: r = 32'(m_mode);
            default: begin
                r = (32'(m_svc) << 8) + ((t < 0) ? 0 : 32'(t));
                if (m_req()) r = r + 32'h8000_0000;
            end
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_prev = '0; m_pend = '0; m_mask = '0; m_mode = '0;
        m_svc = '0; m_hw = '0; m_irq = 1'b0;
    endtask

    task automatic m_step(input bit [5:0] s, input logic [1:0] a,
                          input bit w, input logic [31:0] d);
        bit [5:0] np;
        bit r, clr;
        int t, sv;
        r  = m_req();
        t  = first_set(m_pend & m_mask);
        sv = first_set(m_svc);
        np = m_pend;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                clr = (w && a == 2'd0 && d[i]) ||
                      (w && a == 2'd3 && d[31] && r && t == i);
                if (s[i] && !m_prev[i]) np[i] = 1'b1;
                else if (clr) np[i] = 1'b0;
            end else begin
                np[i] = s[i];
            end
        end
        m_hw  = m_pend & m_mask;
        m_irq = r;
        if (w) begin
            case (a)
                2'd1: m_mask = d[5:0];
                2'd2: m_mode = d[5:0];
                2'd3: begin
                    if (d[31]) begin
                        if (r) m_svc[t] = 1'b1;
                    end else if (sv >= 0) begin
                        m_svc[sv] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        m_pend = np;
        m_prev = s;
    endtask

    bit in_rst;

    initial begin
        // Level source, mask all
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h0, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd1, 1, 32'h3f, 32'h0, 0, 6'h00));
        tbl.push_back(mk(6'h02, 2'd1, 0, 32'h0, 32'h3f, 0, 6'h00));
        tbl.push_back(mk(6'h02, 2'd3, 0, 32'h0, 32'h8000_0001, 0, 6'h00));
        tbl.push_back(mk(6'h02, 2'd0, 0, 32'h0, 32'h02, 1, 6'h02));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h02, 1, 6'h02));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h00, 1, 6'h02));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h0, 0, 6'h00));
        // Edge mode, pulse capture, W1C, set-beats-clear
        tbl.push_back(mk(6'h00, 2'd2, 1, 32'h3f, 32'h0, 0, 6'h00));
        tbl.push_back(mk(6'h04, 2'd0, 0, 32'h0, 32'h00, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h04, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h04, 1, 6'h04));
        tbl.push_back(mk(6'h00, 2'd0, 1, 32'h04, 32'h04, 1, 6'h04));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h00, 1, 6'h04));
        tbl.push_back(mk(6'h04, 2'd0, 0, 32'h0, 32'h00, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h04, 0, 6'h00));
        tbl.push_back(mk(6'h04, 2'd0, 1, 32'h04, 32'h04, 1, 6'h04));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h04, 1, 6'h04));
        tbl.push_back(mk(6'h00, 2'd0, 1, 32'h3f, 32'h04, 1, 6'h04));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h00, 1, 6'h04));
        // Priority and nesting
        tbl.push_back(mk(6'h0c, 2'd0, 0, 32'h0, 32'h00, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h8000_0002, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h8000_0000, 32'h8000_0002, 1, 6'h0c));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h0000_0403, 1, 6'h0c));
        tbl.push_back(mk(6'h01, 2'd3, 0, 32'h0, 32'h0000_0403, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h8000_0400, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h8000_0000, 32'h8000_0400, 1, 6'h09));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h0000_0503, 1, 6'h09));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h0, 32'h0000_0503, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h8000_0000, 32'h0000_0403, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h0000_0403, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h0, 32'h0000_0403, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h8000_0003, 0, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 1, 32'h0, 32'h8000_0003, 1, 6'h08));
        tbl.push_back(mk(6'h00, 2'd3, 0, 32'h0, 32'h8000_0003, 1, 6'h08));
        tbl.push_back(mk(6'h00, 2'd0, 1, 32'h3f, 32'h08, 1, 6'h08));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h00, 1, 6'h08));
        tbl.push_back(mk(6'h00, 2'd0, 0, 32'h0, 32'h00, 0, 6'h00));
        // Masking with all sources active, then unmask bit 5
        tbl.push_back(mk(6'h00, 2'd2, 1, 32'h0, 32'h3f, 0, 6'h00));
        tbl.push_back(mk(6'h00, 2'd1, 1, 32'h0, 32'h3f, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd0, 0, 32'h0, 32'h00, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd0, 0, 32'h0, 32'h3f, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd0, 0, 32'h0, 32'h3f, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd1, 1, 32'h20, 32'h00, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd1, 0, 32'h0, 32'h20, 0, 6'h00));
        tbl.push_back(mk(6'h3f, 2'd3, 0, 32'h0, 32'h8000_0005, 1, 6'h20));
        // Set up irq=1 with insvc=0x01 for the reset sequence
        tbl.push_back(mk(6'h3f, 2'd1, 1, 32'h3f, 32'h20, 1, 6'h20));
        tbl.push_back(mk(6'h3f, 2'd3, 0, 32'h0, 32'h8000_0000, 1, 6'h20));
        tbl.push_back(mk(6'h3f, 2'd3, 1, 32'h8000_0000, 32'h8000_0000, 1, 6'h3f));

        // Reset state
        #5;
        chk("rst irq", irq, 0);
        chk("rst hwint", hwint, 0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1 chk($sformatf("rst dout%0d", a), dout, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            src = tbl[i].src; addr = tbl[i].addr;
            we = tbl[i].we; din = tbl[i].din;
            #1;
            chk($sformatf("row%0d dout", i), dout, tbl[i].dout);
            chk($sformatf("row%0d irq", i), irq, 32'(tbl[i].irq));
            chk($sformatf("row%0d hwint", i), hwint, 32'(tbl[i].hw));
        end

        // Async reset mid-cycle with irq=1 and insvc=0x01
        @(negedge clk);
        we = 1'b0; addr = 2'd3; din = '0;
        #1;
        chk("pre-rst ctrl", dout, 32'h0000_0100);
        chk("pre-rst irq", irq, 1);
        chk("pre-rst hwint", hwint, 32'h3f);
        #2 reset = 1'b0;
        #1;
        chk("async irq", irq, 0);
        chk("async hwint", hwint, 0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1 chk($sformatf("async dout%0d", a), dout, 0);
        end
        m_reset();
        in_rst = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (in_rst) begin
                reset = 1'b1;
                in_rst = 1'b0;
            end
            src  = src ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            addr = 2'($urandom);
            we   = ($urandom_range(0, 2) == 0);
            din  = $urandom;
            #1;
            chk("rnd dout", dout, m_dout(addr));
            chk("rnd irq", irq, 32'(m_irq));
            chk("rnd hwint", hwint, 32'(m_hw));
            if ($urandom_range(0, 299) == 0) begin
                we = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("rnd rst irq", irq, 0);
                chk("rnd rst hwint", hwint, 0);
                chk("rnd rst dout", dout, 0);
                m_reset();
                in_rst = 1'b1;
            end else begin
                m_step(src, addr, we, din);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
